// File: rtl/nand_logic_sweep_unit.sv
// WIDTH-channel selectable 2-input logic unit with registered outputs and a
// truth-table sweep engine that steps the latched function through all four input pairs.
module nand_logic_sweep_unit #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sweep_start,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       truth_table,
  output logic [1:0]       step_idx
);

  localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PreLast = PW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = ~(x & z);
      3'b001:  r = x & z;
      3'b010:  r = x | z;
      3'b011:  r = ~(x | z);
      3'b100:  r = x ^ z;
      3'b101:  r = ~(x ^ z);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [3:0]       tt_q, tt_d;
  logic [1:0]       step_q, step_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] live_y, run_y;

  assign live_y = logic_fn(op, a, b);
  // Sweep operands are the current step index broadcast across every channel.
  assign run_y  = logic_fn(op_q, {WIDTH{step_q[1]}}, {WIDTH{step_q[0]}});

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    tt_d      = tt_q;
    step_d    = step_q;
    pre_d     = pre_q;
    if (!ena) begin
      y_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (sweep_start) begin
            op_d      = op;
            state_d   = StRun;
            tt_d      = 4'b0000;
            step_d    = 2'd0;
            pre_d     = '0;
            y_valid_d = 1'b0;
          end else begin
            y_d       = live_y;
            y_valid_d = 1'b1;
          end
        end
        StRun: begin
          y_d       = run_y;
          y_valid_d = 1'b0;
          if (pre_q == PreLast) begin
            tt_d[step_q] = run_y[0];
            pre_d        = '0;
            if (step_q == 2'd3) begin
              state_d = StDone;
            end else begin
              step_d = step_q + 2'd1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= 3'b000;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      tt_q      <= 4'b0000;
      step_q    <= 2'd0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      tt_q      <= tt_d;
      step_q    <= step_d;
      pre_q     <= pre_d;
    end
  end

  assign y           = y_q;
  assign y_valid     = y_valid_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign truth_table = tt_q;
  assign step_idx    = step_q;

endmodule

// File: tb/tb_nand_logic_sweep_unit.sv
// Bench for nand_logic_sweep_unit: sweep-level behavioural model checked every cycle,
// plus directed literal checks; a second WIDTH=1/STEP_CYCLES=1 instance covers the fast sweep.
module tb_nand_logic_sweep_unit;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       sweep_start = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] y;
  logic       y_valid, busy, done;
  logic [3:0] truth_table;
  logic [1:0] step_idx;
  logic [0:0] y1;
  logic       y_valid1, busy1, done1;
  logic [3:0] tt1;
  logic [1:0] step1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  nand_logic_sweep_unit #(.WIDTH(8), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .op(op), .a(a), .b(b),
    .sweep_start(sweep_start), .y(y), .y_valid(y_valid), .busy(busy), .done(done),
    .truth_table(truth_table), .step_idx(step_idx)
  );

  nand_logic_sweep_unit #(.WIDTH(1), .STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .op(op), .a(a[0:0]), .b(b[0:0]),
    .sweep_start(start1), .y(y1), .y_valid(y_valid1), .busy(busy1), .done(done1),
    .truth_table(tt1), .step_idx(step1)
  );

  function automatic logic [7:0] fn(input logic [2:0] s, input logic [7:0] x, input logic [7:0] z);
    case (s)
      3'd0:    return ~(x & z);
      3'd1:    return x & z;
      3'd2:    return x | z;
      3'd3:    return ~(x | z);
      3'd4:    return x ^ z;
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a sweep is a count of enabled edges since start; step = count / SC.
  logic [7:0] m_y = 8'h00;
  logic       m_yv = 1'b0, m_run = 1'b0, m_done = 1'b0;
  logic [3:0] m_tt = 4'h0;
  logic [2:0] m_op = 3'd0;
  int         m_t = 0, m_step = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = 8'h00; m_yv = 1'b0; m_run = 1'b0; m_done = 1'b0;
      m_tt = 4'h0; m_t = 0; m_step = 0;
    end else if (!ena) begin
      m_yv = 1'b0;
    end else if (m_run) begin
      logic [7:0] r;
      r = fn(m_op, {8{m_step[1]}}, {8{m_step[0]}});
      m_y = r;
      m_yv = 1'b0;
      if (m_t % SC == SC - 1) begin
        m_tt[m_step] = r[0];
        if (m_step == 3) begin m_run = 1'b0; m_done = 1'b1; end
      end
      m_t++;
      if (m_run) m_step = m_t / SC;
    end else if (sweep_start) begin
      m_run = 1'b1; m_done = 1'b0; m_op = op; m_tt = 4'h0;
      m_t = 0; m_step = 0; m_yv = 1'b0;
    end else begin
      m_y = fn(op, a, b);
      m_yv = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("y", y, m_y);
      check("y_valid", y_valid, m_yv);
      check("busy", busy, m_run);
      check("done", done, m_done);
      check("truth_table", truth_table, m_tt);
      check("step_idx", step_idx, m_step[1:0]);
    end
  end

  task automatic run_sweep(input logic [2:0] o, input int inj, input int frz, output int n);
    op = o;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == inj) begin op = 3'b001; sweep_start = 1'b1; end
      if (n == inj + 1) sweep_start = 1'b0;
      if (n == frz) ena = 1'b0;
      if (n == frz + 5) ena = 1'b1;
    end
  endtask

  initial begin
    int n;
    #12;
    check("rst_y", y, 0);
    check("rst_flags", {y_valid, busy, done}, 0);
    check("rst_tt", truth_table, 0);
    check("rst_step", step_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1; op = 3'b000; a = 8'hF0; b = 8'hCC;
    @(negedge clk);
    check("nand_y", y, 8'h3F);
    check("nand_valid", y_valid, 1'b1);
    op = 3'b100;
    @(negedge clk);
    check("xor_y", y, 8'h3C);

    run_sweep(3'b000, -10, -10, n);
    check("nand_sweep_len", n, 16);
    check("nand_tt", truth_table, 4'b0111);
    check("nand_busy_end", busy, 1'b0);

    run_sweep(3'b100, -10, -10, n);
    check("xor_sweep_len", n, 16);
    check("xor_tt", truth_table, 4'b0110);

    run_sweep(3'b011, 5, -10, n);
    check("nor_sweep_len", n, 16);
    check("nor_tt", truth_table, 4'b0001);

    run_sweep(3'b000, -10, 3, n);
    check("freeze_sweep_len", n, 21);
    check("freeze_tt", truth_table, 4'b0111);

    // Async reset while step_idx == 2, observed before the next clock edge.
    op = 3'b010; sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    n = 0;
    while (step_idx != 2'd2 && n < 40) begin @(negedge clk); n++; end
    check("reach_step2", n < 40, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", y, 0);
    check("arst_flags", {y_valid, busy, done}, 0);
    check("arst_tt", truth_table, 0);
    check("arst_step", step_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op = 3'b110; a = 8'hF0;
    @(negedge clk);
    check("nota_y", y, 8'h0F);
    check("nota_valid", y_valid, 1'b1);
    op = 3'b111; a = 8'hA5;
    @(negedge clk);
    check("pass_y", y, 8'hA5);

    op = 3'b110; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("w1_busy", busy1, 1'b1);
    n = 0;
    while (!done1 && n < 20) begin @(negedge clk); n++; end
    check("w1_sweep_len", n, 4);
    check("w1_tt", tt1, 4'b0011);
    check("w1_step", step1, 2'd3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
